edge_maxpool_2x2: RTL

- Downstream stage of the 3x3 Laplacian edge-detection convolution.
- Consumes the raster-order edge-magnitude pixel stream and performs 2x2 max pooling, stride 2, non-overlapping.
- Emits a half-width, half-height edge map with line and frame markers for the next stage (feature extraction / framebuffer writer).
- Uses one half-row line buffer; no full-frame storage.

---
 rtl/edge_maxpool_2x2.sv | 86 ++++++++
 1 files changed

// File: rtl/edge_maxpool_2x2.sv
// edge_maxpool_2x2: 2x2 stride-2 max pooling of a raster-order edge-magnitude
// stream. One half-row line buffer holds the even-row pair maxima; the odd row
// completes each block and emits one pooled pixel one clock after its last beat.
// Optional feature macro: MAXPOOL_BINARIZE_EN (threshold the pooled max to
// all-ones / zero against THRESHOLD).
module edge_maxpool_2x2 #(
   parameter int unsigned WORD_SIZE = 8,
   parameter int unsigned ROW_SIZE  = 540,
   parameter int unsigned COL_SIZE  = 540,
   parameter int unsigned THRESHOLD = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WORD_SIZE-1:0] in_pixel,
   input  logic                 in_sof,
   output logic                 out_valid,
   output logic [WORD_SIZE-1:0] out_pixel,
   output logic                 out_eol,
   output logic                 out_eof
);

   localparam int unsigned XW = $clog2(ROW_SIZE);
   localparam int unsigned YW = $clog2(COL_SIZE);
   localparam logic [XW-1:0] X_LAST = XW'(ROW_SIZE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(COL_SIZE - 1);

   logic [XW-1:0]        x, cx, nx;
   logic [YW-1:0]        y, cy, ny;
   logic [WORD_SIZE-1:0] h;
   logic [WORD_SIZE-1:0] lb [ROW_SIZE/2];
   logic                 x_last, y_last;
   logic [WORD_SIZE-1:0] lb_rd, pair_max, pool_max, pool_out;
   logic                 complete;

   // Effective position (in_sof forces (0,0)), next counters, pooling datapath
   always_comb begin
      cx       = in_sof ? '0 : x;
      cy       = in_sof ? '0 : y;
      x_last   = (cx == X_LAST);
      y_last   = (cy == Y_LAST);
      nx       = x_last ? '0 : cx + 1'b1;
      ny       = x_last ? (y_last ? '0 : cy + 1'b1) : cy;
      lb_rd    = lb[cx[XW-1:1]];
      pair_max = (in_pixel > h) ? in_pixel : h;
      pool_max = (lb_rd > pair_max) ? lb_rd : pair_max;
      complete = in_valid && cx[0] && cy[0];
`ifdef MAXPOOL_BINARIZE_EN
      pool_out = (pool_max >= WORD_SIZE'(THRESHOLD)) ? '1 : '0;
`else
      pool_out = pool_max;
`endif
   end

   // Counters, hold register and the registered output stage
   always_ff @(posedge clk) begin
      if (rst) begin
         x         <= '0;
         y         <= '0;
         h         <= '0;
         out_valid <= 1'b0;
         out_pixel <= '0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else begin
         out_valid <= complete;
         out_eol   <= complete && x_last;
         out_eof   <= complete && x_last && y_last;
         if (complete)
            out_pixel <= pool_out;
         if (in_valid) begin
            x <= nx;
            y <= ny;
            if (!cx[0])
               h <= in_pixel;
         end
      end
   end

   // Even-row pair maxima into the half-row line buffer (not reset: written before read)
   always_ff @(posedge clk) begin
      if (in_valid && cx[0] && !cy[0])
         lb[cx[XW-1:1]] <= pair_max;
   end

endmodule
